mdio_master: RTL and testbench



---
 rtl/lb_mdio_pkg.sv | 51 +++++
 rtl/mdio_clkgen.sv | 67 ++++++
 rtl/mdio_master.sv | 230 +++++++++++++++++++++++
 tb/tb_mdio_master.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_mdio_pkg.sv
// -----------------------------------------------------------------------------
// lb_mdio_pkg
//
// Shared definitions for the Clause-22 MDIO master:
//   - frame field constants (start, opcodes, write turnaround)
//   - preamble / frame lengths and bit positions inside a frame
//   - FSM state encoding
//   - mdio_frame(): assembles the 32-bit frame word, MSB first
//
// Configuration macro used by the importing RTL: MDIO_PREAMBLE_EN.
// -----------------------------------------------------------------------------
package lb_mdio_pkg;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

    localparam int MDIO_PRE_BITS   = 32;
    localparam int MDIO_FRAME_BITS = 32;
    // Frame bit index (0 = first bit on the wire) of the first TA bit and
    // of the first DATA bit.
    localparam int MDIO_TA_BIT     = 14;
    localparam int MDIO_DATA_BIT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } mdio_state_e;

    // Frame word, MSB transmitted first. For reads the TA and DATA fields are
    // never driven onto the pin (the pin is released), so they are filled with
    // ones purely to keep mdio_o at its idle level.
    function automatic logic [31:0] mdio_frame(
        input logic        write,
        input logic [4:0]  phy,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        logic [1:0]  op;
        logic [1:0]  ta;
        logic [15:0] data;
        op   = write ? MDIO_OP_WRITE : MDIO_OP_READ;
        ta   = write ? MDIO_TA_WRITE : 2'b11;
        data = write ? wdata : 16'hFFFF;
        return {MDIO_ST, op, phy, regad, ta, data};
    endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// -----------------------------------------------------------------------------
// mdio_clkgen
//
// MDC generator. A phase counter runs 0..ClkDiv-1 while en_i is high and MDC
// toggles at every terminal count, giving a period of 2*ClkDiv clk_i cycles
// that always starts with the low half. When en_i is low the counter and MDC
// are held at zero, so every frame starts from a known phase.
//
// rise_o / fall_o are combinational one-cycle strobes that are high in the
// cycle whose closing clk_i edge makes MDC go 0->1 / 1->0.
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   synchronous active-high reset
//   en_i    in   run the generator (master busy)
//   mdc_o   out  management clock
//   rise_o  out  MDC rises on the next clk_i edge
//   fall_o  out  MDC falls on the next clk_i edge
// -----------------------------------------------------------------------------
module mdio_clkgen #(
    parameter int ClkDiv = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic mdc_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mdc_q, mdc_d;
    logic            tc;

    assign tc = (cnt_q == CntW'(ClkDiv - 1));

    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!en_i) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (tc) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc_o  = mdc_q;
    assign rise_o = en_i & tc & ~mdc_q;
    assign fall_o = en_i & tc &  mdc_q;

endmodule

// File: rtl/mdio_master.sv
// -----------------------------------------------------------------------------
// mdio_master
//
// Clause-22 MDIO management master. Accepts one register read/write command
// at a time and shifts it out as an MDC/MDIO frame; reads are shifted back in
// from mdio_i through a 2-flop synchronizer.
//
// Configuration: define MDIO_PREAMBLE_EN to send a 32-bit all-ones preamble
// before every frame (64-bit frames). Without it the PRE state is not built and
// frames are 32 bits (preamble suppression; PHY must support it).
//
// Command handshake: a command transfers on a clk_i edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o is high only in IDLE; the source must
// hold cmd_valid_i and the command fields stable until the transfer, and
// cmd_valid_i seen while busy is ignored. rsp_valid_o is a one-cycle pulse with
// no back-pressure; rsp_rdata_o/rsp_err_o are valid with it.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_write_i           1 = write, 0 = read
//   cmd_phy_i, cmd_reg_i  PHY / register address
//   cmd_wdata_i           write data
//   rsp_valid_o           completion pulse
//   rsp_rdata_o           read data (updated on reads only)
//   rsp_err_o             read turnaround error (second TA bit sampled high)
//   busy_o                frame in progress
//   mdc_o                 management clock
//   mdio_o, mdio_oen_o    data out, 1 = release pin
//   mdio_i                data in from the pin
//
// Timing (ClkDiv = C): each bit is C cycles MDC-low then C cycles MDC-high.
// A new bit is driven on the MDC falling edge; read data is sampled when MDC
// rises. With the 2-cycle synchronizer lag, C >= 4 keeps the sample inside
// the bit the PHY is driving.
// -----------------------------------------------------------------------------
module mdio_master
    import lb_mdio_pkg::*;
#(
    parameter int ClkDiv = 25
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_phy_i,
    input  logic [4:0]  cmd_reg_i,
    input  logic [15:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oen_o,
    input  logic        mdio_i
);

    mdio_state_e state_q, state_d;
    logic [4:0]  bit_idx_q, bit_idx_d;   // bit index within PRE or SHIFT
    logic [31:0] frame_q, frame_d;       // remaining frame bits, MSB next
    logic        is_read_q, is_read_d;
    logic        mdio_q, mdio_d;
    logic        oen_q, oen_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] rx_q, rx_d;             // read data shift register
    logic        ta_q, ta_d;             // sampled second TA bit
    logic [1:0]  sync_q, sync_d;         // mdio_i synchronizer, [1] is synced

    logic        busy;
    logic        accept;
    logic        mdc_rise;
    logic        mdc_fall;
    logic [4:0]  next_idx;

    assign busy   = (state_q != ST_IDLE);
    assign accept = cmd_valid_i & (state_q == ST_IDLE);

    mdio_clkgen #(
        .ClkDiv (ClkDiv)
    ) u_clkgen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (busy),
        .mdc_o  (mdc_o),
        .rise_o (mdc_rise),
        .fall_o (mdc_fall)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        frame_d     = frame_q;
        is_read_d   = is_read_q;
        mdio_d      = mdio_q;
        oen_d       = oen_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rx_d        = rx_q;
        ta_d        = ta_q;
        sync_d      = {sync_q[0], mdio_i};
        next_idx    = bit_idx_q + 5'd1;

        case (state_q)
            ST_IDLE: begin
                mdio_d = 1'b1;
                oen_d  = 1'b1;
                if (accept) begin
                    frame_d   = mdio_frame(cmd_write_i, cmd_phy_i, cmd_reg_i, cmd_wdata_i);
                    is_read_d = ~cmd_write_i;
                    bit_idx_d = 5'd0;
                    // ST/OP/PHY/REG are always driven, reads included.
                    oen_d     = 1'b0;
`ifdef MDIO_PREAMBLE_EN
                    state_d   = ST_PRE;
                    mdio_d    = 1'b1;
`else
                    state_d   = ST_SHIFT;
                    mdio_d    = frame_d[31];
`endif
                end
            end

`ifdef MDIO_PREAMBLE_EN
            ST_PRE: begin
                if (mdc_fall) begin
                    if (bit_idx_q == 5'(MDIO_PRE_BITS - 1)) begin
                        state_d   = ST_SHIFT;
                        bit_idx_d = 5'd0;
                        mdio_d    = frame_q[31];
                    end else begin
                        bit_idx_d = next_idx;
                        mdio_d    = 1'b1;
                    end
                end
            end
`endif

            ST_SHIFT: begin
                // Rising edge: capture what the PHY is driving for the
                // current bit (second TA bit, then 16 data bits).
                if (mdc_rise && is_read_q) begin
                    if (bit_idx_q == 5'(MDIO_TA_BIT + 1)) begin
                        ta_d = sync_q[1];
                    end
                    if (bit_idx_q >= 5'(MDIO_DATA_BIT)) begin
                        rx_d = {rx_q[14:0], sync_q[1]};
                    end
                end
                // Falling edge: move to the next bit, or finish after the
                // last one.
                if (mdc_fall) begin
                    if (bit_idx_q == 5'(MDIO_FRAME_BITS - 1)) begin
                        state_d     = ST_DONE;
                        mdio_d      = 1'b1;
                        oen_d       = 1'b1;
                        rsp_valid_d = 1'b1;
                        if (is_read_q) begin
                            rdata_d = rx_q;
                            err_d   = ta_q;
                        end else begin
                            err_d   = 1'b0;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        frame_d   = {frame_q[30:0], 1'b0};
                        mdio_d    = frame_q[30];
                        // Reads hand the pin to the PHY from the first TA bit.
                        oen_d     = is_read_q & (next_idx >= 5'(MDIO_TA_BIT));
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                mdio_d  = 1'b1;
                oen_d   = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                mdio_d  = 1'b1;
                oen_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= 5'd0;
            frame_q     <= '0;
            is_read_q   <= 1'b0;
            mdio_q      <= 1'b1;
            oen_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 16'h0000;
            err_q       <= 1'b0;
            rx_q        <= 16'h0000;
            ta_q        <= 1'b0;
            sync_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            frame_q     <= frame_d;
            is_read_q   <= is_read_d;
            mdio_q      <= mdio_d;
            oen_q       <= oen_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rx_q        <= rx_d;
            ta_q        <= ta_d;
            sync_q      <= sync_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = busy;
    assign mdio_o      = mdio_q;
    assign mdio_oen_o  = oen_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mdio_master.sv
// -----------------------------------------------------------------------------
// tb_mdio_master
//
// Self-checking bench for mdio_master with ClkDiv = 4. A PHY model watches
// MDC: on each rising edge it records mdio_o / mdio_oen_o and, when answering
// a read, drives TA=0 and the data bits onto mdio_i just after the edge.
// Expected frames, response data and latency come from the frame-format
// rules written as plain concatenations. Honours MDIO_PREAMBLE_EN.
// -----------------------------------------------------------------------------
module tb_mdio_master;

    localparam int CLK_DIV = 4;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif
    localparam int NBITS = PRE + 32;
    localparam int LAT   = 1 + 2 * CLK_DIV * NBITS;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [4:0]  cmd_phy_i;
    logic [4:0]  cmd_reg_i;
    logic [15:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        mdc_o;
    logic        mdio_o;
    logic        mdio_oen_o;
    logic        mdio_i;

    mdio_master #(
        .ClkDiv (CLK_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_phy_i   (cmd_phy_i),
        .cmd_reg_i   (cmd_reg_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .mdc_o       (mdc_o),
        .mdio_o      (mdio_o),
        .mdio_oen_o  (mdio_oen_o),
        .mdio_i      (mdio_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected {rsp_err_o, rsp_rdata_o} per command.
    logic [16:0] exp_q[$];
    logic [15:0] last_rdata = 16'h0000;

    // ---------------- PHY model ----------------
    int          phy_mode  = 0;        // 0: pull-up only, 1: answer reads
    logic [15:0] phy_rdata = 16'h0000;
    int          rise_idx  = 0;
    int          phy_nxt;
    logic [63:0] cap_o     = '0;
    logic [63:0] cap_oen   = '0;

    always @(posedge mdc_o) begin
        cap_o    = {cap_o[62:0], mdio_o};
        cap_oen  = {cap_oen[62:0], mdio_oen_o};
        rise_idx = rise_idx + 1;
        #1;
        phy_nxt = rise_idx - PRE;      // frame bit the PHY drives next
        if (phy_mode == 1 && phy_nxt == 15)
            mdio_i = 1'b0;
        else if (phy_mode == 1 && phy_nxt >= 16 && phy_nxt <= 31)
            mdio_i = phy_rdata[31 - phy_nxt];
        else
            mdio_i = 1'b1;
    end

    // ---------------- reference model ----------------
    // Bits as seen on the wire, first bit in the highest captured position.
    // Released read bits are set to 1 and masked by model_oen.
    function automatic logic [63:0] model_o(input bit wr, input logic [4:0] phy,
                                            input logic [4:0] ra, input logic [15:0] wd);
        logic [31:0] f;
        if (wr) f = {2'b01, 2'b01, phy, ra, 2'b10, wd};
        else    f = {2'b01, 2'b10, phy, ra, 18'h3FFFF};
        if (PRE == 32) return {32'hFFFF_FFFF, f};
        return {32'h0, f};
    endfunction

    function automatic logic [63:0] model_oen(input bit wr);
        if (wr) return 64'h0;
        return 64'h0000_0000_0003_FFFF;   // TA and DATA released on reads
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input bit wr, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] wd, input bit hold,
                         output int acc_cyc, output bit ok);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_phy_i   = phy;
        cmd_reg_i   = ra;
        cmd_wdata_i = wd;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        acc_cyc  = cyc;
        rise_idx = 0;
        cap_o    = '0;
        cap_oen  = '0;
        if (!hold) begin
            @(posedge clk);
            #1;
            cmd_valid_i = 1'b0;
        end
    endtask

    task automatic wait_rsp(output int rcyc, output logic err, output logic [15:0] data,
                            output bit ok, output int ready_hi);
        ok = 1'b0; ready_hi = 0; rcyc = 0; err = 1'b0; data = 16'h0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                ok = 1'b1; rcyc = cyc; err = rsp_err_o; data = rsp_rdata_o;
                break;
            end
            if (cmd_ready_o) ready_hi++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1; cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        n_checks++; if (mdc_o !== 1'b0) begin n_fail++; $display("FAIL reset_mdc: got %b want 0", mdc_o); end
        n_checks++; if (mdio_o !== 1'b1) begin n_fail++; $display("FAIL reset_mdio: got %b want 1", mdio_o); end
        n_checks++; if (mdio_oen_o !== 1'b1) begin n_fail++; $display("FAIL reset_oen: got %b want 1", mdio_oen_o); end
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        n_checks++; if (rsp_rdata_o !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", rsp_rdata_o); end
        n_checks++; if (rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", rsp_err_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o); end
    endtask

    // One complete command with full checking of frame, latency and response.
    task automatic test_frame(input bit wr, input logic [4:0] phy, input logic [4:0] ra,
                              input logic [15:0] wd, input int mode, input logic [15:0] rd,
                              input string name);
        logic [16:0] e;
        logic [63:0] eo, eoen;
        int          acc, rc, rdy;
        bit          ok;
        logic        er;
        logic [15:0] dt;
        phy_mode  = wr ? 0 : mode;
        phy_rdata = rd;
        if (wr)             exp_q.push_back({1'b0, last_rdata});
        else if (mode == 1) exp_q.push_back({1'b0, rd});
        else                exp_q.push_back({1'b1, 16'hFFFF});
        if (!wr) last_rdata = (mode == 1) ? rd : 16'hFFFF;
        eo   = model_o(wr, phy, ra, wd);
        eoen = model_oen(wr);
        issue(wr, phy, ra, wd, 1'b0, acc, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_accept: got timeout want accept", name); end
        wait_rsp(rc, er, dt, ok, rdy);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL %s_rsp: got timeout want rsp_valid", name);
        end else begin
            n_checks++;
            if (rc - acc != LAT) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, rc - acc, LAT); end
            n_checks++;
            if ({er, dt} !== e) begin n_fail++; $display("FAIL %s_rsp_data: got err=%b data=%h want err=%b data=%h", name, er, dt, e[16], e[15:0]); end
            n_checks++;
            if (rise_idx != NBITS) begin n_fail++; $display("FAIL %s_bits: got %0d want %0d", name, rise_idx, NBITS); end
            n_checks++;
            if ((cap_o | eoen) !== (eo | eoen)) begin n_fail++; $display("FAIL %s_frame: got %h want %h", name, cap_o | eoen, eo | eoen); end
            n_checks++;
            if (cap_oen !== eoen) begin n_fail++; $display("FAIL %s_oen: got %h want %h", name, cap_oen, eoen); end
            n_checks++;
            if (rdy != 0) begin n_fail++; $display("FAIL %s_ready_busy: got %0d cycles want 0", name, rdy); end
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got %b want 0", name, rsp_valid_o); end
    endtask

    task automatic test_write();
        test_frame(1'b1, 5'h01, 5'h00, 16'h1140, 0, 16'h0, "write");
    endtask

    task automatic test_read();
        test_frame(1'b0, 5'h01, 5'h02, 16'h0, 1, 16'h0141, "read");
    endtask

    task automatic test_silent_read();
        test_frame(1'b0, 5'h01, 5'h03, 16'h0, 0, 16'h0, "silent_read");
        // write after a read must leave rsp_rdata_o at 0xFFFF
        test_frame(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   16'($urandom), 0, 16'h0, "write_hold");
    endtask

    task automatic test_back_to_back();
        logic [4:0]  p1, r1, p2, r2;
        logic [15:0] wd, rd;
        logic [16:0] e;
        logic [63:0] eo;
        int          acc1, acc2, rc1, rc2, rdy1, rdy2;
        bit          ok1, ok2, okr1, okr2;
        logic        er;
        logic [15:0] dt;
        p1 = 5'($urandom_range(0, 31)); r1 = 5'($urandom_range(0, 31)); wd = 16'($urandom);
        p2 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31)); rd = 16'($urandom);
        phy_mode = 0;
        exp_q.push_back({1'b0, last_rdata});
        eo = model_o(1'b1, p1, r1, wd);
        issue(1'b1, p1, r1, wd, 1'b1, acc1, ok1);
        wait_rsp(rc1, er, dt, okr1, rdy1);
        e = exp_q.pop_front();
        n_checks++;
        if (!(ok1 && okr1)) begin
            n_fail++; $display("FAIL b2b_first: got timeout want completion");
        end else begin
            n_checks++;
            if ({er, dt} !== e) begin n_fail++; $display("FAIL b2b_wr_rsp: got err=%b data=%h want err=%b data=%h", er, dt, e[16], e[15:0]); end
            n_checks++;
            if (rdy1 != 0) begin n_fail++; $display("FAIL b2b_wr_ready: got %0d want 0", rdy1); end
            n_checks++;
            if (cap_o !== eo) begin n_fail++; $display("FAIL b2b_wr_frame: got %h want %h", cap_o, eo); end
        end
        // cmd_valid_i still high: switch fields to the read right away
        phy_mode  = 1;
        phy_rdata = rd;
        exp_q.push_back({1'b0, rd});
        last_rdata = rd;
        issue(1'b0, p2, r2, 16'h0, 1'b0, acc2, ok2);
        n_checks++;
        if (acc2 - rc1 != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", acc2 - rc1); end
        wait_rsp(rc2, er, dt, okr2, rdy2);
        e = exp_q.pop_front();
        n_checks++;
        if (!(ok2 && okr2)) begin
            n_fail++; $display("FAIL b2b_second: got timeout want completion");
        end else begin
            n_checks++;
            if ({er, dt} !== e) begin n_fail++; $display("FAIL b2b_rd_rsp: got err=%b data=%h want err=%b data=%h", er, dt, e[16], e[15:0]); end
            n_checks++;
            if (rdy2 != 0) begin n_fail++; $display("FAIL b2b_rd_ready: got %0d want 0", rdy2); end
            n_checks++;
            if (rc2 - acc2 != LAT) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d want %0d", rc2 - acc2, LAT); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int acc, pulses;
        bit ok, seen;
        phy_mode = 0;
        issue(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom),
              1'b0, acc, ok);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rise_idx >= PRE + 9) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL midrst_reach: got timeout want bit %0d", PRE + 8); end
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++; if (mdc_o !== 1'b0) begin n_fail++; $display("FAIL midrst_mdc: got %b want 0", mdc_o); end
        n_checks++; if (mdio_oen_o !== 1'b1) begin n_fail++; $display("FAIL midrst_oen: got %b want 1", mdio_oen_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        rst_i = 1'b0;
        last_rdata = 16'h0000;
        pulses = 0;
        repeat (LAT + 20) begin
            @(negedge clk);
            if (rsp_valid_o) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", pulses); end
        test_frame(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   16'($urandom), 0, 16'h0, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_frame(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 16'($urandom),
                       int'($urandom_range(0, 1)), 16'($urandom), "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_phy_i   = 5'h0;
        cmd_reg_i   = 5'h0;
        cmd_wdata_i = 16'h0;
        mdio_i      = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_silent_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
